// File: rtl/regfile_access_controller.sv
// ============================================================================
// regfile_access_controller
// ----------------------------------------------------------------------------
// Arbiter and sequencer that sits in front of a two-read / one-write register
// array. The core pipeline and the debug module share the array's read and
// write selects. The block grants at most one requester per cycle and drives
// the array selects and store value for the granted requester. It samples
// the array read buses at the grant edge and returns the read data,
// registered, on a one-cycle response pulse in the following cycle.
//
// A debug halt mode (RUN/HALTED) locks the core out. A starvation counter
// forces a waiting debug request ahead of the core after STARVE_LIMIT
// consecutive refused cycles.
//
// Parameters
//   XLEN         : data width
//   SELECT_LEN   : register select width (select 0 means "no register")
//   STARVE_LIMIT : refused debug cycles before debug wins over core (1..15)
//
// Ports
//   clk, reset_n                     : clock (rising edge), async active-low reset
//   core_req_valid / core_req_ready  : core handshake (ready is combinational)
//   core_rs1, core_rs2               : core read selects
//   core_we, core_rd, core_wdata     : core write enable / select / data
//   core_resp_valid                  : one-cycle pulse, core read data valid
//   core_rs1_data, core_rs2_data     : registered core read data
//   dbg_req_valid / dbg_req_ready    : debug handshake (ready is combinational)
//   dbg_we, dbg_addr, dbg_wdata      : debug single-register access
//   dbg_resp_valid, dbg_rdata        : debug response pulse and data
//   dbg_halt_req, dbg_halted         : halt mode request and status
//   ra_store, ra_enable_a/b          : array write / read selects (0 = none)
//   ra_store_value                   : array write data
//   ra_a_bus, ra_b_bus               : array read buses (undriven when select is 0)
// ============================================================================
module regfile_access_controller #(
    parameter int XLEN         = 32,
    parameter int SELECT_LEN   = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  core_req_valid,
    output logic                  core_req_ready,
    input  logic [SELECT_LEN-1:0] core_rs1,
    input  logic [SELECT_LEN-1:0] core_rs2,
    input  logic                  core_we,
    input  logic [SELECT_LEN-1:0] core_rd,
    input  logic [XLEN-1:0]       core_wdata,
    output logic                  core_resp_valid,
    output logic [XLEN-1:0]       core_rs1_data,
    output logic [XLEN-1:0]       core_rs2_data,

    input  logic                  dbg_req_valid,
    output logic                  dbg_req_ready,
    input  logic                  dbg_we,
    input  logic [SELECT_LEN-1:0] dbg_addr,
    input  logic [XLEN-1:0]       dbg_wdata,
    output logic                  dbg_resp_valid,
    output logic [XLEN-1:0]       dbg_rdata,
    input  logic                  dbg_halt_req,
    output logic                  dbg_halted,

    output logic [SELECT_LEN-1:0] ra_store,
    output logic [SELECT_LEN-1:0] ra_enable_a,
    output logic [SELECT_LEN-1:0] ra_enable_b,
    output logic [XLEN-1:0]       ra_store_value,
    input  logic [XLEN-1:0]       ra_a_bus,
    input  logic [XLEN-1:0]       ra_b_bus
);

    // ------------------------------------------------------------------------
    // Constants and types
    // ------------------------------------------------------------------------
    localparam logic [SELECT_LEN-1:0] SEL_NONE_C   = {SELECT_LEN{1'b0}};
    localparam logic [XLEN-1:0]       DATA_ZERO_C  = {XLEN{1'b0}};
    localparam logic [3:0]            STARVE_MAX_C = 4'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------

    // Select 0 addresses no register and the array leaves its bus undriven,
    // so the sampled value is forced to zero instead of propagating Z/X.
    function automatic logic [XLEN-1:0] mask_read(
        input logic [SELECT_LEN-1:0] sel,
        input logic [XLEN-1:0]       bus
    );
        logic [XLEN-1:0] result;
        if (sel == SEL_NONE_C) begin
            result = DATA_ZERO_C;
        end else begin
            result = bus;
        end
        return result;
    endfunction

    // Register 0 is not writable: a write aimed at it becomes "no write".
    function automatic logic [SELECT_LEN-1:0] store_sel(
        input logic                  we,
        input logic [SELECT_LEN-1:0] sel
    );
        logic [SELECT_LEN-1:0] result;
        if (we) begin
            result = sel;
        end else begin
            result = SEL_NONE_C;
        end
        return result;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                state_r;
    logic [3:0]            starve_cnt_r;

    logic                  gnt_core_s;
    logic                  gnt_dbg_s;
    logic [SELECT_LEN-1:0] sel_a_s;
    logic [SELECT_LEN-1:0] sel_b_s;
    logic [SELECT_LEN-1:0] sel_store_s;
    logic [XLEN-1:0]       store_value_s;
    logic                  starved_s;

    assign starved_s = (starve_cnt_r == STARVE_MAX_C);

    // Grant arbitration: at most one requester per cycle, none during reset.
    always_comb begin
        gnt_core_s = 1'b0;
        gnt_dbg_s  = 1'b0;
        if (!reset_n) begin
            gnt_core_s = 1'b0;
            gnt_dbg_s  = 1'b0;
        end else begin
            case (state_r)
                ST_HALTED: begin
                    // Core is locked out entirely while halted.
                    gnt_core_s = 1'b0;
                    gnt_dbg_s  = dbg_req_valid;
                end
                ST_RUN: begin
                    if (dbg_req_valid && starved_s) begin
                        gnt_dbg_s = 1'b1;
                    end else if (core_req_valid) begin
                        gnt_core_s = 1'b1;
                    end else if (dbg_req_valid) begin
                        gnt_dbg_s = 1'b1;
                    end else begin
                        gnt_core_s = 1'b0;
                        gnt_dbg_s  = 1'b0;
                    end
                end
                default: begin
                    gnt_core_s = 1'b0;
                    gnt_dbg_s  = 1'b0;
                end
            endcase
        end
    end

    // Array select / write-data mux for the granted requester.
    always_comb begin
        sel_a_s       = SEL_NONE_C;
        sel_b_s       = SEL_NONE_C;
        sel_store_s   = SEL_NONE_C;
        store_value_s = DATA_ZERO_C;
        if (gnt_core_s) begin
            sel_a_s       = core_rs1;
            sel_b_s       = core_rs2;
            sel_store_s   = store_sel(core_we, core_rd);
            store_value_s = core_wdata;
        end else if (gnt_dbg_s) begin
            // Debug accesses one register, through port A only.
            sel_a_s       = dbg_addr;
            sel_b_s       = SEL_NONE_C;
            sel_store_s   = store_sel(dbg_we, dbg_addr);
            store_value_s = dbg_wdata;
        end else begin
            sel_a_s       = SEL_NONE_C;
            sel_b_s       = SEL_NONE_C;
            sel_store_s   = SEL_NONE_C;
            store_value_s = DATA_ZERO_C;
        end
    end

    assign core_req_ready = gnt_core_s;
    assign dbg_req_ready  = gnt_dbg_s;
    assign ra_enable_a    = sel_a_s;
    assign ra_enable_b    = sel_b_s;
    assign ra_store       = sel_store_s;
    assign ra_store_value = store_value_s;

    // RUN/HALTED mode FSM with registered halted status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_RUN;
            dbg_halted <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (dbg_halt_req) begin
                        state_r    <= ST_HALTED;
                        dbg_halted <= 1'b1;
                    end else begin
                        state_r    <= ST_RUN;
                        dbg_halted <= 1'b0;
                    end
                end
                ST_HALTED: begin
                    if (!dbg_halt_req) begin
                        state_r    <= ST_RUN;
                        dbg_halted <= 1'b0;
                    end else begin
                        state_r    <= ST_HALTED;
                        dbg_halted <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_RUN;
                    dbg_halted <= 1'b0;
                end
            endcase
        end
    end

    // Starvation counter: counts consecutive refused debug cycles, saturating.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt_r <= 4'd0;
        end else if (!dbg_req_valid || gnt_dbg_s) begin
            starve_cnt_r <= 4'd0;
        end else if (!starved_s) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Core response: sample buses at the grant edge, pulse valid one cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_resp_valid <= 1'b0;
            core_rs1_data   <= DATA_ZERO_C;
            core_rs2_data   <= DATA_ZERO_C;
        end else begin
            core_resp_valid <= gnt_core_s;
            if (gnt_core_s) begin
                // Buses still show pre-write contents here: read-before-write.
                core_rs1_data <= mask_read(sel_a_s, ra_a_bus);
                core_rs2_data <= mask_read(sel_b_s, ra_b_bus);
            end else begin
                core_rs1_data <= core_rs1_data;
                core_rs2_data <= core_rs2_data;
            end
        end
    end

    // Debug response: same one-cycle latency, data from port A.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dbg_resp_valid <= 1'b0;
            dbg_rdata      <= DATA_ZERO_C;
        end else begin
            dbg_resp_valid <= gnt_dbg_s;
            if (gnt_dbg_s) begin
                dbg_rdata <= mask_read(sel_a_s, ra_a_bus);
            end else begin
                dbg_rdata <= dbg_rdata;
            end
        end
    end

endmodule

// File: tb/tb_regfile_access_controller.sv
// ============================================================================
// tb_regfile_access_controller
// ----------------------------------------------------------------------------
// Directed bench for regfile_access_controller. A behavioural register array
// (write at the clock edge, combinational read) is attached to the ra_* ports.
// Inputs change 1 time unit after the rising edge; outputs are checked
// between edges.
// ============================================================================
module tb_regfile_access_controller;

    logic        clk;
    logic        reset_n;
    logic        core_req_valid;
    logic        core_req_ready;
    logic [4:0]  core_rs1;
    logic [4:0]  core_rs2;
    logic        core_we;
    logic [4:0]  core_rd;
    logic [31:0] core_wdata;
    logic        core_resp_valid;
    logic [31:0] core_rs1_data;
    logic [31:0] core_rs2_data;
    logic        dbg_req_valid;
    logic        dbg_req_ready;
    logic        dbg_we;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_resp_valid;
    logic [31:0] dbg_rdata;
    logic        dbg_halt_req;
    logic        dbg_halted;
    logic [4:0]  ra_store;
    logic [4:0]  ra_enable_a;
    logic [4:0]  ra_enable_b;
    logic [31:0] ra_store_value;
    logic [31:0] ra_a_bus;
    logic [31:0] ra_b_bus;

    int pass_cnt;
    int total_cnt;

    // Register array model. An undriven bus (select 0) is represented by a
    // non-zero garbage pattern so that select-0 masking is observable.
    logic [31:0] regs [32];

    always @(posedge clk) begin
        if (ra_store != 5'd0) regs[ra_store] <= ra_store_value;
    end

    assign ra_a_bus = (ra_enable_a == 5'd0) ? 32'hA5A5_A5A5 : regs[ra_enable_a];
    assign ra_b_bus = (ra_enable_b == 5'd0) ? 32'h5A5A_5A5A : regs[ra_enable_b];

    regfile_access_controller #(
        .XLEN(32), .SELECT_LEN(5), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_rs1(core_rs1), .core_rs2(core_rs2),
        .core_we(core_we), .core_rd(core_rd), .core_wdata(core_wdata),
        .core_resp_valid(core_resp_valid),
        .core_rs1_data(core_rs1_data), .core_rs2_data(core_rs2_data),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
        .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_resp_valid(dbg_resp_valid), .dbg_rdata(dbg_rdata),
        .dbg_halt_req(dbg_halt_req), .dbg_halted(dbg_halted),
        .ra_store(ra_store), .ra_enable_a(ra_enable_a), .ra_enable_b(ra_enable_b),
        .ra_store_value(ra_store_value), .ra_a_bus(ra_a_bus), .ra_b_bus(ra_b_bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        core_req_valid = 1'b1; core_rs1 = 5'd3; core_rs2 = 5'd4;
        core_we = 1'b1; core_rd = 5'd3; core_wdata = 32'h1234_5678;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (core_req_ready !== 1'b0) $display("FAIL rst_core_ready: got %0b want 0", core_req_ready); else pass_cnt++;
        total_cnt++; if (ra_enable_a !== 5'd0) $display("FAIL rst_ra_enable_a: got %0d want 0", ra_enable_a); else pass_cnt++;
        total_cnt++; if (ra_store !== 5'd0) $display("FAIL rst_ra_store: got %0d want 0", ra_store); else pass_cnt++;
        total_cnt++; if (ra_store_value !== 32'd0) $display("FAIL rst_ra_store_value: got %h want 0", ra_store_value); else pass_cnt++;
        total_cnt++; if (core_resp_valid !== 1'b0) $display("FAIL rst_core_resp_valid: got %0b want 0", core_resp_valid); else pass_cnt++;
        total_cnt++; if (dbg_resp_valid !== 1'b0) $display("FAIL rst_dbg_resp_valid: got %0b want 0", dbg_resp_valid); else pass_cnt++;
        total_cnt++; if (core_rs1_data !== 32'd0) $display("FAIL rst_core_rs1_data: got %h want 0", core_rs1_data); else pass_cnt++;
        total_cnt++; if (dbg_rdata !== 32'd0) $display("FAIL rst_dbg_rdata: got %h want 0", dbg_rdata); else pass_cnt++;
        total_cnt++; if (dbg_halted !== 1'b0) $display("FAIL rst_dbg_halted: got %0b want 0", dbg_halted); else pass_cnt++;
        core_req_valid = 1'b0; core_we = 1'b0;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_core_rw;
        // Write x5 = 0xDEADBEEF
        core_req_valid = 1'b1; core_we = 1'b1; core_rd = 5'd5; core_wdata = 32'hDEAD_BEEF;
        core_rs1 = 5'd0; core_rs2 = 5'd0;
        #1;
        total_cnt++; if (core_req_ready !== 1'b1) $display("FAIL wr_core_ready: got %0b want 1", core_req_ready); else pass_cnt++;
        total_cnt++; if (ra_store !== 5'd5) $display("FAIL wr_ra_store: got %0d want 5", ra_store); else pass_cnt++;
        total_cnt++; if (ra_store_value !== 32'hDEAD_BEEF) $display("FAIL wr_ra_store_value: got %h want deadbeef", ra_store_value); else pass_cnt++;
        tick();
        total_cnt++; if (core_resp_valid !== 1'b1) $display("FAIL wr_resp_valid: got %0b want 1", core_resp_valid); else pass_cnt++;
        total_cnt++; if (core_rs1_data !== 32'd0) $display("FAIL wr_resp_rs1_data: got %h want 0", core_rs1_data); else pass_cnt++;
        // Read rs1=5, rs2=0
        core_we = 1'b0; core_rs1 = 5'd5; core_rs2 = 5'd0;
        #1;
        total_cnt++; if (ra_enable_a !== 5'd5) $display("FAIL rd_ra_enable_a: got %0d want 5", ra_enable_a); else pass_cnt++;
        total_cnt++; if (ra_store !== 5'd0) $display("FAIL rd_ra_store: got %0d want 0", ra_store); else pass_cnt++;
        tick();
        core_req_valid = 1'b0;
        total_cnt++; if (core_resp_valid !== 1'b1) $display("FAIL rd_resp_valid: got %0b want 1", core_resp_valid); else pass_cnt++;
        total_cnt++; if (core_rs1_data !== 32'hDEAD_BEEF) $display("FAIL rd_rs1_data: got %h want deadbeef", core_rs1_data); else pass_cnt++;
        total_cnt++; if (core_rs2_data !== 32'd0) $display("FAIL rd_rs2_data_x0: got %h want 0", core_rs2_data); else pass_cnt++;
        tick();
        total_cnt++; if (core_resp_valid !== 1'b0) $display("FAIL rd_resp_pulse_end: got %0b want 0", core_resp_valid); else pass_cnt++;
    endtask

    task automatic test_read_before_write;
        core_req_valid = 1'b1; core_we = 1'b1; core_rd = 5'd7; core_wdata = 32'h0000_0011;
        core_rs1 = 5'd0; core_rs2 = 5'd0;
        tick();
        // Same-grant read and write of x7
        core_rs1 = 5'd7; core_rs2 = 5'd7; core_wdata = 32'h0000_0022;
        tick();
        total_cnt++; if (core_rs1_data !== 32'h11) $display("FAIL rbw_rs1_old: got %h want 11", core_rs1_data); else pass_cnt++;
        total_cnt++; if (core_rs2_data !== 32'h11) $display("FAIL rbw_rs2_old: got %h want 11", core_rs2_data); else pass_cnt++;
        core_we = 1'b0;
        tick();
        core_req_valid = 1'b0;
        total_cnt++; if (core_resp_valid !== 1'b1) $display("FAIL b2b_resp_valid: got %0b want 1", core_resp_valid); else pass_cnt++;
        total_cnt++; if (core_rs1_data !== 32'h22) $display("FAIL rbw_rs1_new: got %h want 22", core_rs1_data); else pass_cnt++;
        tick();
    endtask

    task automatic test_starvation;
        logic exp_d;
        core_req_valid = 1'b1; core_we = 1'b0; core_rs1 = 5'd5; core_rs2 = 5'd7;
        dbg_req_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd7;
        for (int c = 0; c < 10; c++) begin
            exp_d = (c == 4) || (c == 9);
            #1;
            total_cnt++; if (dbg_req_ready !== exp_d) $display("FAIL starve_dbg_ready c%0d: got %0b want %0b", c, dbg_req_ready, exp_d); else pass_cnt++;
            total_cnt++; if (core_req_ready !== !exp_d) $display("FAIL starve_core_ready c%0d: got %0b want %0b", c, core_req_ready, !exp_d); else pass_cnt++;
            tick();
            total_cnt++; if (dbg_resp_valid !== exp_d) $display("FAIL starve_dbg_resp c%0d: got %0b want %0b", c, dbg_resp_valid, exp_d); else pass_cnt++;
            total_cnt++; if (core_resp_valid !== !exp_d) $display("FAIL starve_core_resp c%0d: got %0b want %0b", c, core_resp_valid, !exp_d); else pass_cnt++;
            if (exp_d) begin
                total_cnt++; if (dbg_rdata !== 32'h22) $display("FAIL starve_dbg_rdata c%0d: got %h want 22", c, dbg_rdata); else pass_cnt++;
            end
        end
    endtask

    task automatic test_halt;
        core_req_valid = 1'b1; dbg_req_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5;
        dbg_halt_req = 1'b1;
        #1;
        total_cnt++; if (core_req_ready !== 1'b1) $display("FAIL halt_req_core_ready: got %0b want 1", core_req_ready); else pass_cnt++;
        total_cnt++; if (dbg_req_ready !== 1'b0) $display("FAIL halt_req_dbg_ready: got %0b want 0", dbg_req_ready); else pass_cnt++;
        total_cnt++; if (dbg_halted !== 1'b0) $display("FAIL halt_req_halted: got %0b want 0", dbg_halted); else pass_cnt++;
        tick();
        for (int c = 1; c < 4; c++) begin
            if (c == 3) dbg_halt_req = 1'b0;
            #1;
            total_cnt++; if (dbg_halted !== 1'b1) $display("FAIL halted_flag c%0d: got %0b want 1", c, dbg_halted); else pass_cnt++;
            total_cnt++; if (dbg_req_ready !== 1'b1) $display("FAIL halted_dbg_ready c%0d: got %0b want 1", c, dbg_req_ready); else pass_cnt++;
            total_cnt++; if (core_req_ready !== 1'b0) $display("FAIL halted_core_ready c%0d: got %0b want 0", c, core_req_ready); else pass_cnt++;
            tick();
            total_cnt++; if (dbg_rdata !== 32'hDEAD_BEEF) $display("FAIL halted_dbg_rdata c%0d: got %h want deadbeef", c, dbg_rdata); else pass_cnt++;
        end
        #1;
        total_cnt++; if (dbg_halted !== 1'b0) $display("FAIL release_halted: got %0b want 0", dbg_halted); else pass_cnt++;
        total_cnt++; if (core_req_ready !== 1'b1) $display("FAIL release_core_ready: got %0b want 1", core_req_ready); else pass_cnt++;
        total_cnt++; if (dbg_req_ready !== 1'b0) $display("FAIL release_dbg_ready: got %0b want 0", dbg_req_ready); else pass_cnt++;
        tick();
        core_req_valid = 1'b0; dbg_req_valid = 1'b0;
        tick();
    endtask

    task automatic test_x0;
        dbg_req_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd0; dbg_wdata = 32'hFFFF_FFFF;
        #1;
        total_cnt++; if (dbg_req_ready !== 1'b1) $display("FAIL x0_dbg_ready: got %0b want 1", dbg_req_ready); else pass_cnt++;
        total_cnt++; if (ra_store !== 5'd0) $display("FAIL x0_ra_store: got %0d want 0", ra_store); else pass_cnt++;
        tick();
        dbg_req_valid = 1'b0; dbg_we = 1'b0;
        total_cnt++; if (dbg_resp_valid !== 1'b1) $display("FAIL x0_dbg_resp_valid: got %0b want 1", dbg_resp_valid); else pass_cnt++;
        total_cnt++; if (dbg_rdata !== 32'd0) $display("FAIL x0_dbg_rdata: got %h want 0", dbg_rdata); else pass_cnt++;
        core_req_valid = 1'b1; core_we = 1'b0; core_rs1 = 5'd0; core_rs2 = 5'd0;
        tick();
        core_req_valid = 1'b0;
        total_cnt++; if (core_rs1_data !== 32'd0) $display("FAIL x0_core_rs1_data: got %h want 0", core_rs1_data); else pass_cnt++;
        total_cnt++; if (core_rs2_data !== 32'd0) $display("FAIL x0_core_rs2_data: got %h want 0", core_rs2_data); else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid;
        core_req_valid = 1'b1; core_we = 1'b0; core_rs1 = 5'd5; core_rs2 = 5'd7;
        tick();
        #1;
        total_cnt++; if (core_req_ready !== 1'b1) $display("FAIL mid_core_ready: got %0b want 1", core_req_ready); else pass_cnt++;
        #2;
        reset_n = 1'b0;
        #1;
        total_cnt++; if (core_resp_valid !== 1'b0) $display("FAIL mid_async_resp_valid: got %0b want 0", core_resp_valid); else pass_cnt++;
        total_cnt++; if (core_rs1_data !== 32'd0) $display("FAIL mid_async_rs1_data: got %h want 0", core_rs1_data); else pass_cnt++;
        total_cnt++; if (ra_enable_a !== 5'd0) $display("FAIL mid_ra_enable_a: got %0d want 0", ra_enable_a); else pass_cnt++;
        total_cnt++; if (ra_enable_b !== 5'd0) $display("FAIL mid_ra_enable_b: got %0d want 0", ra_enable_b); else pass_cnt++;
        tick();
        total_cnt++; if (core_resp_valid !== 1'b0) $display("FAIL mid_resp_dropped: got %0b want 0", core_resp_valid); else pass_cnt++;
        core_req_valid = 1'b0;
        reset_n = 1'b1;
        tick();
        total_cnt++; if (core_resp_valid !== 1'b0) $display("FAIL mid_no_replay: got %0b want 0", core_resp_valid); else pass_cnt++;
        total_cnt++; if (dbg_halted !== 1'b0) $display("FAIL mid_state_run: got %0b want 0", dbg_halted); else pass_cnt++;
        core_req_valid = 1'b1;
        #1;
        total_cnt++; if (core_req_ready !== 1'b1) $display("FAIL mid_core_grant_after: got %0b want 1", core_req_ready); else pass_cnt++;
        tick();
        core_req_valid = 1'b0;
        tick();
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0;
        reset_n = 1'b0;
        core_req_valid = 1'b0; core_rs1 = 5'd0; core_rs2 = 5'd0;
        core_we = 1'b0; core_rd = 5'd0; core_wdata = 32'd0;
        dbg_req_valid = 1'b0; dbg_we = 1'b0; dbg_addr = 5'd0; dbg_wdata = 32'd0;
        dbg_halt_req = 1'b0;
        test_reset();
        test_core_rw();
        test_read_before_write();
        test_starvation();
        test_halt();
        test_x0();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/regfile_access_controller.md
# regfile_access_controller

Sequencer and arbiter in front of `register_array`, sharing its two read selects and one write select between the core pipeline and the debug module. Each cycle it grants at most one requester, drives the array selects and store value, samples the read buses, and returns registered read data one cycle later. Supports a debug halt mode that locks the core out, plus starvation protection for debug traffic.

## Interface
- `XLEN`, 32, data width
- `SELECT_LEN`, 5, register select width
- `STARVE_LIMIT`, 4, consecutive refused debug cycles before debug is forced ahead of core (range 1..15)

Clock and reset are decided: one clock `clk`; `reset_n` is asynchronous, active-low.
- `clk` in 1: clock, rising edge
- `reset_n` in 1: asynchronous active-low reset
- `core_req_valid` in 1: core request present
- `core_req_ready` out 1: core request accepted this cycle (combinational)
- `core_rs1`, `core_rs2` in SELECT_LEN: core read selects
- `core_we` in 1: core write enable
- `core_rd` in SELECT_LEN: core write select
- `core_wdata` in XLEN: core write data
- `core_resp_valid` out 1: one-cycle pulse, core read data valid
- `core_rs1_data`, `core_rs2_data` out XLEN: core read data
- `dbg_req_valid` in 1, `dbg_req_ready` out 1: debug handshake
- `dbg_we` in 1, `dbg_addr` in SELECT_LEN, `dbg_wdata` in XLEN: debug access (single register)
- `dbg_resp_valid` out 1, `dbg_rdata` out XLEN: debug response
- `dbg_halt_req` in 1: request halt mode; `dbg_halted` out 1: in HALTED
- `ra_store`, `ra_enable_a`, `ra_enable_b` out SELECT_LEN: array selects (0 = none)
- `ra_store_value` out XLEN: array write data
- `ra_a_bus`, `ra_b_bus` in XLEN: array read buses (may be Z)

## Operation
- FSM RUN/HALTED, reset RUN. RUN→HALTED at the edge where `dbg_halt_req`=1. HALTED→RUN at the edge where `dbg_halt_req`=0. `dbg_halted` = (state==HALTED).
- Grant (combinational, at most one):
  - HALTED: debug if `dbg_req_valid`; core never.
  - RUN: debug if `dbg_req_valid` && starve_cnt==STARVE_LIMIT; else core if `core_req_valid`; else debug if `dbg_req_valid`.
- starve_cnt: reset 0. +1 (saturating at STARVE_LIMIT) each cycle `dbg_req_valid`=1 and debug is not granted; cleared when debug is granted or `dbg_req_valid`=0.
- Core grant: `ra_enable_a`=`core_rs1`, `ra_enable_b`=`core_rs2`, `ra_store`=`core_we`?`core_rd`:0, `ra_store_value`=`core_wdata`.
- Debug grant: `ra_enable_a`=`dbg_addr`, `ra_enable_b`=0, `ra_store`=`dbg_we`?`dbg_addr`:0, value=`dbg_wdata`.
- No grant: all `ra_*` outputs 0.
- Read data is sampled at the grant edge. A select of 0 returns 0 regardless of the bus, so no Z or X is ever propagated. Write to select 0 is suppressed (`ra_store`=0).
- Read-before-write: a read that selects the register written in the same grant returns the old value. A grant in the next cycle sees the new value.
- Responses have no backpressure. The requester must take the data on the pulse.

## Timing
- Latency 1: `*_resp_valid` is high exactly the cycle after the granted cycle, for reads and writes alike. Write-only responses carry data of the read selects.
- Throughput 1 grant/cycle. Back-to-back grants give back-to-back pulses.
- Reset values: `*_resp_valid`=0, all data outputs 0, `dbg_halted`=0, starve_cnt=0. `ra_*` are 0 while `reset_n`=0.
- Reset asserted mid-operation clears outputs immediately. An in-flight response is dropped and is not replayed after reset.
- `dbg_halt_req` and a core request in the same cycle while in RUN: the core is still granted that cycle and is locked out from the next cycle.

## Test plan
- Core writes x5=0xDEADBEEF, then reads rs1=5, rs2=0 → next-cycle `core_rs1_data`=0xDEADBEEF, `core_rs2_data`=0, `core_resp_valid` a 1-cycle pulse.
- Same-cycle read/write x7 (old value 0x11, new 0x22) → response 0x11. The following read returns 0x22.
- Core valid every cycle, debug valid from cycle 0 → debug granted on cycle STARVE_LIMIT (4), starve_cnt returns to 0, core granted on all other cycles.
- `dbg_halt_req`=1 with both valid → core granted only in the request cycle. `dbg_halted`=1 next cycle, debug always granted. Release → core granted again one cycle later.
- Debug write to x0 with 0xFFFFFFFF → `ra_store`=0. A later read of x0 returns 0 while `ra_a_bus` is Z.
- `reset_n` pulled low the cycle after a grant → `core_resp_valid` stays 0, all `ra_*` are 0, state is RUN after release.
